// File: rtl/cpu_pkg.sv
// Pipeline-wide constants shared by control, forwarding, hazard and write-back logic.
package cpu_pkg;
    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = $clog2(NREG);

    localparam int WB_REGWRITE_BIT = 1;
    localparam int WB_MEMTOREG_BIT = 0;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/reg_array.sv
// NREG x XLEN storage: one synchronous write port, two asynchronous read ports.
module reg_array
    import cpu_pkg::*;
#(
    parameter int XLEN_P = XLEN,
    parameter int NREG_P = NREG
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        we_i,
    input  logic [$clog2(NREG_P)-1:0]   waddr_i,
    input  logic [XLEN_P-1:0]           wdata_i,
    input  logic [$clog2(NREG_P)-1:0]   raddr_a_i,
    input  logic [$clog2(NREG_P)-1:0]   raddr_b_i,
    output logic [XLEN_P-1:0]           rdata_a_o,
    output logic [XLEN_P-1:0]           rdata_b_o
);
    logic [XLEN_P-1:0] mem_q [NREG_P];
    logic [XLEN_P-1:0] mem_d [NREG_P];

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    // Reset clears every entry and overrides a concurrent write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG_P; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result select, register file commit with same-cycle read bypass,
// and a free-running count of retired register writes.
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int NREG = cpu_pkg::NREG,
    parameter int CNTW = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [1:0]                WB_i,
    input  logic [XLEN-1:0]           data1_i,
    input  logic [XLEN-1:0]           data2_i,
    input  logic [$clog2(NREG)-1:0]   RDaddr_i,
    input  logic [$clog2(NREG)-1:0]   RSaddr_i,
    input  logic [$clog2(NREG)-1:0]   RTaddr_i,
    output logic [XLEN-1:0]           RSdata_o,
    output logic [XLEN-1:0]           RTdata_o,
    output logic [XLEN-1:0]           WBdata_o,
    output logic                      RegWrite_o,
    output logic [CNTW-1:0]           retire_cnt_o
);
    logic [XLEN-1:0] wb_data;
    logic            reg_write;
    logic [XLEN-1:0] rs_stored;
    logic [XLEN-1:0] rt_stored;
    logic [CNTW-1:0] retire_cnt_q;
    logic [CNTW-1:0] retire_cnt_d;

    always_comb begin
        wb_data   = WB_i[WB_MEMTOREG_BIT] ? data1_i : data2_i;
        reg_write = WB_i[WB_REGWRITE_BIT] && (RDaddr_i != REG_ZERO);
    end

    reg_array #(
        .XLEN_P (XLEN),
        .NREG_P (NREG)
    ) u_reg_array (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (reg_write),
        .waddr_i   (RDaddr_i),
        .wdata_i   (wb_data),
        .raddr_a_i (RSaddr_i),
        .raddr_b_i (RTaddr_i),
        .rdata_a_o (rs_stored),
        .rdata_b_o (rt_stored)
    );

    // r0 is hardwired to zero; otherwise a same-cycle write to the read address wins over storage.
    always_comb begin
        RSdata_o = rs_stored;
        if (RSaddr_i == REG_ZERO) begin
            RSdata_o = '0;
        end else if (reg_write && (RSaddr_i == RDaddr_i)) begin
            RSdata_o = wb_data;
        end

        RTdata_o = rt_stored;
        if (RTaddr_i == REG_ZERO) begin
            RTdata_o = '0;
        end else if (reg_write && (RTaddr_i == RDaddr_i)) begin
            RTdata_o = wb_data;
        end
    end

    // Writes to r0 still retire, so the count keys off RegWrite alone.
    always_comb begin
        retire_cnt_d = retire_cnt_q + CNTW'(WB_i[WB_REGWRITE_BIT]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign WBdata_o     = wb_data;
    assign RegWrite_o   = reg_write;
    assign retire_cnt_o = retire_cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Randomised and directed bench for wb_regfile against an array-based reference model.
module tb_wb_regfile;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  WB_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic [4:0]  RDaddr_i;
    logic [4:0]  RSaddr_i;
    logic [4:0]  RTaddr_i;
    logic [31:0] RSdata_o;
    logic [31:0] RTdata_o;
    logic [31:0] WBdata_o;
    logic        RegWrite_o;
    logic [31:0] retire_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] regs_m [32];
    logic [31:0] cnt_m;

    wb_regfile dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .WB_i         (WB_i),
        .data1_i      (data1_i),
        .data2_i      (data2_i),
        .RDaddr_i     (RDaddr_i),
        .RSaddr_i     (RSaddr_i),
        .RTaddr_i     (RTaddr_i),
        .RSdata_o     (RSdata_o),
        .RTdata_o     (RTdata_o),
        .WBdata_o     (WBdata_o),
        .RegWrite_o   (RegWrite_o),
        .retire_cnt_o (retire_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (rst_i === 1'b0) begin
            assert (!$isunknown(WB_i)) else $error("WB_i unknown outside reset");
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic [1:0] wb,
                                               input logic [4:0] rd, input logic [31:0] v);
        if (a == 5'd0) return 32'd0;
        if (wb[1] && rd != 5'd0 && a == rd) return v;
        return regs_m[a];
    endfunction

    // One pipeline cycle: drive at negedge, check combinational view, then commit into the model.
    task automatic step(input logic [1:0] wb, input logic [4:0] rd, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rst);
        logic [31:0] v;
        @(negedge clk_i);
        WB_i = wb; RDaddr_i = rd; data1_i = d1; data2_i = d2;
        RSaddr_i = rs; RTaddr_i = rt; rst_i = rst;
        v = wb[0] ? d1 : d2;
        #1;
        chk("wbdata", WBdata_o, v);
        chk("regwrite", {31'd0, RegWrite_o}, {31'd0, wb[1] && rd != 5'd0});
        chk("rsdata", RSdata_o, model_read(rs, wb, rd, v));
        chk("rtdata", RTdata_o, model_read(rt, wb, rd, v));
        chk("retire", retire_cnt_o, cnt_m);
        @(posedge clk_i);
        if (rst) begin
            foreach (regs_m[i]) regs_m[i] = 32'd0;
            cnt_m = 32'd0;
        end else begin
            if (wb[1] && rd != 5'd0) regs_m[rd] = v;
            if (wb[1]) cnt_m = cnt_m + 32'd1;
        end
    endtask

    initial begin
        logic [4:0] rd, rs, rt;
        foreach (regs_m[i]) regs_m[i] = 'x;
        cnt_m = 'x;
        rst_i = 1'b1; WB_i = 2'b00; data1_i = '0; data2_i = '0;
        RDaddr_i = '0; RSaddr_i = '0; RTaddr_i = '0;

        // Reset with a colliding write, then read the target back.
        step(2'b10, 5'd5, 32'h0, 32'hDEAD, 5'd5, 5'd0, 1'b1);
        step(2'b10, 5'd5, 32'h0, 32'hDEAD, 5'd5, 5'd5, 1'b1);
        step(2'b00, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5, 1'b0);
        chk("reg5_after_reset", RSdata_o, 32'd0);

        // ALU write then readback.
        step(2'b10, 5'd3, 32'h0, 32'h12345678, 5'd1, 5'd2, 1'b0);
        step(2'b00, 5'd0, 32'h0, 32'h0, 5'd3, 5'd3, 1'b0);
        chk("reg3_readback", RSdata_o, 32'h12345678);

        // Load select with both ports bypassed.
        step(2'b11, 5'd7, 32'hCAFEF00D, 32'h1, 5'd7, 5'd7, 1'b0);
        chk("bypass_rs", RSdata_o, 32'hCAFEF00D);
        chk("bypass_rt", RTdata_o, 32'hCAFEF00D);

        // r0 write is dropped but still retires.
        step(2'b10, 5'd0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0);
        step(2'b00, 5'd0, 32'h0, 32'h0, 5'd0, 5'd7, 1'b0);

        // No-write cycle: no bypass, no retire.
        step(2'b01, 5'd4, 32'hAA, 32'h0, 5'd4, 5'd4, 1'b0);
        step(2'b00, 5'd0, 32'h0, 32'h0, 5'd4, 5'd3, 1'b0);

        // Counter wrap from all-ones.
        @(negedge clk_i);
        force dut.retire_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt_q;
        cnt_m = 32'hFFFFFFFF;
        step(2'b10, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
        step(2'b00, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);

        // Reset wins over a concurrent write.
        step(2'b10, 5'd12, 32'h0, 32'h77, 5'd12, 5'd12, 1'b0);
        step(2'b10, 5'd9, 32'h0, 32'h55, 5'd9, 5'd12, 1'b1);
        step(2'b00, 5'd0, 32'h0, 32'h0, 5'd9, 5'd12, 1'b0);

        // Random traffic with occasional mid-stream reset.
        for (int n = 0; n < 500; n++) begin
            rd = 5'($urandom_range(0, 31));
            rs = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rt = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            step(2'($urandom), rd, $urandom, $urandom, rs, rt,
                 ($urandom_range(0, 63) == 0));
        end

        step(2'b00, 5'd0, 32'h0, 32'h0, 5'd1, 5'd2, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
